// File: rtl/uart_tx_serializer_pkg.sv
// Shared definitions for the UART transmitter and receiver: FSM state encodings, default line settings,
// and the clocks-per-bit derivation. Optional parity is selected with UART_TX_PARITY_EN.
package uart_tx_serializer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam int DEF_CLK_FREQ = 50_000_000;
    localparam int DEF_BAUD     = 115_200;

    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int baud_cnt_w(input int cpb);
        return (cpb <= 2) ? 1 : $clog2(cpb);
    endfunction

endpackage

// File: rtl/uart_tx_serializer_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 and wraps, held at zero while cleared.
// o_bit_done pulses for one cycle on the terminal count.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_bit_done
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             terminal;

    assign terminal   = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign o_bit_done = terminal & ~i_clear;

    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (i_clear || terminal) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// Byte-to-serial 8N1 UART transmitter with a one-byte holding register in front of the shifter.
// Define UART_TX_PARITY_EN to insert a parity bit (odd when PARITY_ODD=1, else even) after the data bits.
module uart_tx_serializer
    import uart_tx_serializer_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int PARITY_ODD = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_wdata,
    input  logic       i_wvalid,
    output logic       o_wready,
    output logic       o_tx,
    output logic       o_busy
);

    localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
    localparam int CNT_W        = baud_cnt_w(CLKS_PER_BIT);

    uart_state_e state_q, state_d;
    logic        tx_q, tx_d;
    logic        hold_full_q, hold_full_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        bit_done;
    logic        accept;
    logic        load;

`ifdef UART_TX_PARITY_EN
    logic        par_q, par_d;
`else
    logic        unused_parity_cfg;
    assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

    // Counter runs only while a frame is on the line, so every state starts at count zero.
    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_baud (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (state_q == ST_IDLE),
        .o_bit_done (bit_done)
    );

    assign accept   = i_wvalid & ~hold_full_q;
    assign o_wready = ~hold_full_q;
    assign o_tx     = tx_q;
    assign o_busy   = (state_q != ST_IDLE) | hold_full_q;

    always_comb begin
        state_d     = state_q;
        tx_d        = tx_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        load        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d       = par_q;
`endif

        // tx_d is the line level for the state being entered, keeping o_tx a clean flop output.
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (hold_full_q) begin
                    load    = 1'b1;
                    state_d = ST_START;
                    tx_d    = 1'b0;
                end
            end
            ST_START: begin
                if (bit_done) begin
                    state_d = ST_DATA;
                    tx_d    = shift_q[0];
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = ST_PARITY;
                        tx_d    = par_q;
`else
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_done) begin
                    state_d = ST_STOP;
                    tx_d    = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    if (hold_full_q) begin
                        load    = 1'b1;
                        state_d = ST_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Load and accept are exclusive: one needs the holding register full, the other empty.
        if (load) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d       = (PARITY_ODD != 0) ? ~^hold_q : ^hold_q;
`endif
        end else if (accept) begin
            hold_d      = i_wdata;
            hold_full_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            tx_q        <= 1'b1;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= 3'd0;
        end else begin
            state_q     <= state_d;
            tx_q        <= tx_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
        end
    end

    always_ff @(posedge i_clk) begin
        hold_q  <= hold_d;
        shift_q <= shift_d;
`ifdef UART_TX_PARITY_EN
        par_q   <= par_d;
`endif
    end

endmodule
